mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide unit for RV32M ops, sitting in the Execute stage beside the ALU.
- Decode flags M-ops (opcode 0110011, funct7 = 0000001) and the Execute stage asserts start.
- The block latches the operands and runs an iterative shift-add multiply or restoring divide, one bit per cycle.
- It holds the pipeline stalled until the result is ready, then releases it with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  valid M-op present in Execute this cycle
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  rs1 operand
- b  input  XLEN  rs2 operand
- flush  input  1  synchronous abort; Execute instruction is squashed
- stall  output  1  freeze F/D/E pipeline registers
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  rd write data, valid while done=1

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset state: state=IDLE, stall=0, done=0, result=0, all internal registers cleared.
- States and transitions:
  - IDLE: start=1 latches a, b, funct3 and the operand signs, and loads absolute values (signed ops only).
    - Next state is MUL for funct3[2]=0.
    - Next state is DIV for funct3[2]=1 in the normal case.
    - Next state is DONE directly for a divide special case.
  - MUL: 32 cycles. Each cycle, if multiplier LSB=1, add the multiplicand to the upper half of the 2*XLEN accumulator, then shift right 1. The iteration counter counts 0..XLEN-1, then the state goes to DONE.
  - DIV: 32 cycles of restoring division. Shift {rem, quot} left 1, trial-subtract the divisor from rem; if non-negative, keep it and set quot LSB to 1. After XLEN iterations the state goes to DONE.
  - DONE: done=1 and result is driven. The state always returns to IDLE. start is ignored here, because it is the same instruction that is leaving Execute.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - The 2*XLEN product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Result selection:
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
- Special cases (resolved in IDLE, latency 1 cycle to DONE):
  - b=0: DIV/DIVU return all-ones; REM/REMU return a.
  - Signed overflow, DIV with a=0x80000000 and b=0xFFFFFFFF: returns 0x80000000; REM returns 0.
- stall:
  - stall = (state==IDLE and start and not flush) or state in {MUL, DIV}.
  - stall=0 in DONE, so the pipeline advances on that edge and captures result.
- Latency, start sampled at edge 0:
  - Normal ops: done=1 in cycle XLEN+1 (33), so stall is high for 33 cycles.
  - Special cases: done in cycle 1.
- Flush: flush=1 in any state forces the next state to IDLE with no done pulse. flush in IDLE together with start means the op is not accepted and stall=0.
- Reset mid-operation: returns to IDLE next cycle and no done is produced.
- Busy operation: start, a, b and funct3 are not re-sampled while in MUL or DIV; the latched copies are used.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (−3) -> stall high 33 cycles; done in cycle 33 with result=0xFFFFFFEB; stall low in that cycle.
- MULH a=b=0x80000000 -> result=0x40000000. MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> result=0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 -> result=0xFFFFFFFD. REM with the same operands -> result=0xFFFFFFFF. DIVU a=100, b=7 -> 14; REMU with the same operands -> 2.
- DIVU a=5, b=0 -> done at cycle 1, result=0xFFFFFFFF. REM a=5, b=0 -> 5. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 at cycle 1; REM with the same operands -> 0.
- Start MUL, assert flush at cycle 10 -> stall=0 from cycle 11, no done. A new DIVU 9/3 issued at cycle 12 -> result=3 at cycle 45.
- Assert rst at cycle 5 of a DIV -> IDLE next cycle, done never asserted, result=0. Back-to-back MUL ops (start held through DONE then a new op) -> exactly one done per op.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide: one bit per cycle, 33-cycle latency (1 for divide special cases).
// Stalls the F/D/E pipeline while busy and releases it with a one-cycle done pulse.
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              neg_p;
  logic              neg_r;
  logic [XLEN-1:0]   opd;
  // MUL: {partial product, multiplier}; DIV: {remainder, quotient/dividend}
  logic [2*XLEN-1:0] acc;

  logic              a_sgn, b_sgn, na, nb;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    a_sgn    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    na       = a_sgn & a[XLEN-1];
    nb       = b_sgn & b[XLEN-1];
    abs_a    = na ? -a : a;
    abs_b    = nb ? -b : b;
    div_zero = (b == '0);
    div_ovf  = !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    special  = funct3[2] && (div_zero || div_ovf);
    if (div_zero)
      special_res = funct3[1] ? a : '1;
    else
      special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [XLEN-1:0]   quo, rmd, mul_res, div_res;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    prod      = neg_p ? -mul_next : mul_next;
    mul_res   = (op == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opd};
    if (div_diff[XLEN])
      div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    quo       = div_next[XLEN-1:0];
    rmd       = div_next[2*XLEN-1:XLEN];
    // Remainder follows the dividend's sign, quotient follows the sign difference
    div_res   = op[1] ? (neg_r ? -rmd : rmd) : (neg_p ? -quo : quo);
  end

  assign stall = (state == MUL) || (state == DIV) || ((state == IDLE) && start && !flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      opd    <= '0;
      acc    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op    <= funct3;
              neg_p <= na ^ nb;
              neg_r <= na;
              cnt   <= '0;
              if (special) begin
                result <= special_res;
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                acc   <= {{XLEN{1'b0}}, (funct3[2] ? abs_a : abs_b)};
                opd   <= funct3[2] ? abs_b : abs_a;
                state <= funct3[2] ? DIV : MUL;
              end
            end
          end
          MUL: begin
            acc <= mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN-1)) begin
              result <= mul_res;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
          DIV: begin
            acc <= div_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN-1)) begin
              result <= div_res;
              done   <= 1'b1;
              state  <= DONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed vector bench for mdu_sequencer: arithmetic table plus flush/reset/back-to-back sequences.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        flush;
  logic        stall, done;
  logic [31:0] result;

  int compared = 0;
  int mismatched = 0;

  mdu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b),
    .flush(flush), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one op at the next negedge; cycle 0 is the start cycle.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] exp, input int lat);
    int stalls;
    int done_at;
    logic [31:0] res;
    stalls  = 0;
    done_at = -1;
    res     = 'x;
    @(negedge clk);
    start = 1'b1; funct3 = f; a = aa; b = bb;
    #1;
    if (stall) stalls++;
    @(negedge clk);
    // Scramble inputs to show the latched copies are used
    start = 1'b0; funct3 = 3'($urandom); a = $urandom; b = $urandom;
    for (int k = 1; k <= 60; k++) begin
      #1;
      if (stall) stalls++;
      if (done) begin
        done_at = k;
        res     = result;
        break;
      end
      @(negedge clk);
    end
    chk({nm, " done cycle"}, 32'(done_at), 32'(lat));
    chk({nm, " stall cycles"}, 32'(stalls), 32'(lat));
    chk({nm, " result"}, res, exp);
    @(negedge clk);
    #1;
    chk({nm, " done pulse width"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int nd;
    int seen;
    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        1};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
    vecs[12] = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{3'b111, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1};
    vecs[14] = '{3'b000, 32'h00010000, 32'h00010000, 32'd0,        33};
    vecs[15] = '{3'b011, 32'h00010000, 32'h00010000, 32'd1,        33};
    vecs[16] = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
    vecs[17] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33};

    rst = 1'b1; start = 1'b0; funct3 = '0; a = '0; b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset stall", {31'b0, stall}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Flush in IDLE with start: op rejected
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; a = 32'd3; b = 32'd4;
    #1;
    chk("idle flush stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("idle flush not accepted", {31'b0, stall}, 32'd0);

    // Flush mid-MUL at cycle 10, new DIVU at cycle 12
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; a = 32'd9; b = 32'd9;
    seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) flush = 1'b1;
      #1;
      if (done) seen++;
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush stall released", {31'b0, stall}, 32'd0);
    chk("flush no done", 32'(seen + int'(done)), 32'd0);
    run_op("divu after flush", 3'b101, 32'd9, 32'd3, 32'd3, 33);

    // Reset at cycle 5 of a DIV
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; a = 32'd100; b = 32'd7;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst mid-div stall", {31'b0, stall}, 32'd0);
    chk("rst mid-div result", result, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done) seen++;
    end
    chk("rst mid-div no done", 32'(seen), 32'd0);

    // Back-to-back MULs: start held through DONE, then a second op
    nd = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      start = (k <= 34);
      funct3 = 3'b000;
      a = (k < 34) ? 32'd3 : 32'd6;
      b = (k < 34) ? 32'd5 : 32'd7;
      #1;
      if (done) begin
        nd++;
        if (nd == 1) begin
          chk("b2b first cycle", 32'(k), 32'd33);
          chk("b2b first result", result, 32'd15);
        end else if (nd == 2) begin
          chk("b2b second cycle", 32'(k), 32'd67);
          chk("b2b second result", result, 32'd42);
        end
      end
    end
    chk("b2b done count", 32'(nd), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
